// File: rtl/gcm_pkg.sv
// Shared GCM constants and the single-step multiply-by-x reduction in GCM bit order.
package gcm_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam logic [7:0]  GCM_R   = 8'hE1;

    // Bit 127 is the x^0 coefficient, so multiplying by x is a right shift.
    // A coefficient leaving x^127 folds back in as x^7 + x^2 + x + 1.
    function automatic logic [BLOCK_W-1:0] mulx(input logic [BLOCK_W-1:0] v);
        logic [BLOCK_W-1:0] shifted;
        shifted = {1'b0, v[BLOCK_W-1:1]};
        if (v[0]) begin
            return shifted ^ {GCM_R, {(BLOCK_W-8){1'b0}}};
        end
        return shifted;
    endfunction

endpackage

// File: rtl/galois_mul_digit_step.sv
// One digit of the GF(2^128) shift-and-add multiply, unrolled over DIGIT_W bits of X.
module galois_mul_digit_step
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic [DIGIT_W-1:0] xdigit,
    input  logic [BLOCK_W-1:0] zin,
    input  logic [BLOCK_W-1:0] vin,
    output logic [BLOCK_W-1:0] zout,
    output logic [BLOCK_W-1:0] vout
);

    logic [BLOCK_W-1:0] z_acc;
    logic [BLOCK_W-1:0] v_acc;

    // The MSB of the digit is the lowest-order X coefficient, so it is consumed first.
    always_comb begin
        z_acc = zin;
        v_acc = vin;
        for (int j = 0; j < DIGIT_W; j++) begin
            if (xdigit[DIGIT_W-1-j]) begin
                z_acc = z_acc ^ v_acc;
            end
            v_acc = mulx(v_acc);
        end
    end

    assign zout = z_acc;
    assign vout = v_acc;

endmodule

// File: rtl/galois_mul_digit.sv
// Digit-serial GF(2^128) multiplier with a GHASH accumulate mode: Z = X*Y or Z = (ACC^X)*Y.
module galois_mul_digit
    import gcm_pkg::*;
#(
    parameter int DIGIT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic               clear_acc,
    input  logic [BLOCK_W-1:0] X,
    input  logic [BLOCK_W-1:0] Y,
    output logic [BLOCK_W-1:0] Z,
    output logic               busy,
    output logic               valid,
    output logic [0:0]         fsm_state
);

    localparam int CYCLES = BLOCK_W / DIGIT_W;
    localparam int CNT_W  = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    generate
        if (!(DIGIT_W == 1 || DIGIT_W == 2 || DIGIT_W == 4 ||
              DIGIT_W == 8 || DIGIT_W == 16 || DIGIT_W == 32)) begin : g_bad_digit
            $error("galois_mul_digit: DIGIT_W must be 1, 2, 4, 8, 16 or 32");
        end
    endgenerate

    logic [0:0]         state;
    logic [BLOCK_W-1:0] xw;
    logic [BLOCK_W-1:0] vw;
    logic [BLOCK_W-1:0] zw;
    logic [CNT_W-1:0]   cnt;
    logic [BLOCK_W-1:0] acc;

    logic [BLOCK_W-1:0] z_next;
    logic [BLOCK_W-1:0] v_next;
    logic [BLOCK_W-1:0] acc_eff;

    galois_mul_digit_step #(
        .DIGIT_W(DIGIT_W)
    ) u_step (
        .xdigit(xw[BLOCK_W-1 -: DIGIT_W]),
        .zin   (zw),
        .vin   (vw),
        .zout  (z_next),
        .vout  (v_next)
    );

    // A clear arriving with start wins, so the new GHASH chain begins from zero.
    assign acc_eff = clear_acc ? '0 : acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            xw    <= '0;
            vw    <= '0;
            zw    <= '0;
            cnt   <= '0;
            acc   <= '0;
            Z     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == ST_IDLE) begin
                if (clear_acc) begin
                    acc <= '0;
                end
                if (start) begin
                    xw    <= mode ? (acc_eff ^ X) : X;
                    vw    <= Y;
                    zw    <= '0;
                    cnt   <= '0;
                    state <= ST_RUN;
                end
            end else begin
                xw  <= xw << DIGIT_W;
                vw  <= v_next;
                zw  <= z_next;
                cnt <= cnt + CNT_ONE;
                // Both modes update ACC so a plain multiply can seed a GHASH chain.
                if (cnt == CNT_LAST) begin
                    Z     <= z_next;
                    acc   <= z_next;
                    valid <= 1'b1;
                    state <= ST_IDLE;
                end
            end
        end
    end

    assign busy      = (state == ST_RUN);
    assign fsm_state = state;

endmodule
